// File: rtl/if_id_skid_stage_if.sv
// Valid/ready handshake bundle carrying an instruction word and its PC.
// The fetch side of the stage uses the slave view, the decode side the master view.
interface if_id_skid_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;

    modport master (output valid, output instr, output pc, input ready);
    modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a two-entry skid buffer, synchronous flush,
// NOP bubble presentation, decoded opcode output and a saturating stall counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   EMPTY | nothing held; outputs show NOP_WORD / PC 0
//   ONE   | main register holds the head entry, skid register unused
//   FULL  | main holds the head, skid holds the next (younger) entry
//
// in_ready is a flop, so decode back-pressure never reaches fetch combinationally.
module if_id_skid_stage #(
    parameter int                 INSTR_W  = 32,
    parameter int                 PC_W     = 32,
    parameter int                 OPC_W    = 6,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    if_id_skid_stage_if.slave    fetch,
    if_id_skid_stage_if.master   decode,
    output logic [OPC_W-1:0]     out_opcode,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_count
);

    // Encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_q;
    logic               out_valid;
    logic               in_fire;
    logic               out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = fetch.valid && in_ready_q;
    assign out_fire  = out_valid && decode.ready;

    // Next-state and data-path selection; flush overrides every handshake.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = NOP_WORD;
            main_pc_d    = '0;
            skid_instr_d = NOP_WORD;
            skid_pc_d    = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_instr_d = fetch.instr;
                        main_pc_d    = fetch.pc;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = fetch.instr;
                        main_pc_d    = fetch.pc;
                    end else if (in_fire) begin
                        skid_instr_d = fetch.instr;
                        skid_pc_d    = fetch.pc;
                        state_d      = ST_FULL;
                    end else if (out_fire) begin
                        main_instr_d = NOP_WORD;
                        main_pc_d    = '0;
                        state_d      = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        skid_instr_d = NOP_WORD;
                        skid_pc_d    = '0;
                        state_d      = ST_ONE;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_WORD;
                    main_pc_d    = '0;
                    skid_instr_d = NOP_WORD;
                    skid_pc_d    = '0;
                end
            endcase
        end
    end

    // State, entry registers and the registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_WORD;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_WORD;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= (state_d != ST_FULL);
        end
    end

    // Count cycles where decode stalls a valid head; saturates, ignores flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !decode.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign fetch.ready  = in_ready_q;
    assign decode.valid = out_valid;
    assign decode.instr = main_instr_q;
    assign decode.pc    = main_pc_q;
    assign out_opcode   = main_instr_q[INSTR_W-1 -: OPC_W];
    assign occupancy    = 2'(state_q);
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus randomized traffic, all
// checked against a queue-based scoreboard held in a separate monitor process.
module tb_if_id_skid_stage;

    localparam int          INSTR_W = 32;
    localparam int          PC_W    = 32;
    localparam int          OPC_W   = 6;
    localparam int          CNT_W   = 2;
    localparam int          CNT_MAX = 3;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [OPC_W-1:0] out_opcode;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_count;

    if_id_skid_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) fetch_if ();
    if_id_skid_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) decode_if ();

    if_id_skid_stage #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .OPC_W   (OPC_W),
        .NOP_WORD(NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetch      (fetch_if),
        .decode     (decode_if),
        .out_opcode (out_opcode),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     stall_model = 0;
    int     delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible head and stage status with the scoreboard
    // every cycle, pops on a completed (non-flushed) handshake.
    initial begin
        forever begin
            int n;
            @(negedge clk);
            #1;
            n = exp_q.size();
            chk("occupancy", occupancy, n);
            chk("out_valid", decode_if.valid, n > 0);
            chk("in_ready", fetch_if.ready, n < 2);
            chk("stall_count", stall_count, stall_model);
            if (n == 0) begin
                chk("idle_instr", decode_if.instr, NOP);
                chk("idle_pc", decode_if.pc, 0);
                chk("idle_opcode", out_opcode, NOP >> (INSTR_W - OPC_W));
            end else begin
                chk("head_instr", decode_if.instr, exp_q[0].instr);
                chk("head_pc", decode_if.pc, exp_q[0].pc);
                chk("head_opcode", out_opcode, exp_q[0].instr >> (INSTR_W - OPC_W));
            end
            if (!rst && !flush && n > 0 && decode_if.ready) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (!rst && n > 0 && !decode_if.ready && stall_model < CNT_MAX)
                stall_model++;
        end
    end

    // One stimulus cycle; accepted inputs become expected outputs.
    task automatic cyc(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
        @(negedge clk);
        fetch_if.valid  = iv;
        fetch_if.instr  = ins;
        fetch_if.pc     = pc;
        decode_if.ready = ordy;
        flush           = fl;
        #2;
        if (fl)
            exp_q.delete();
        else if (iv && fetch_if.ready)
            exp_q.push_back('{instr: ins, pc: pc});
    endtask

    // Reset asserted between edges, after the monitor has sampled the cycle.
    task automatic mid_reset(input bit check_now);
        @(negedge clk);
        fetch_if.valid = 1'b0;
        flush          = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        if (check_now) begin
            chk("rst_out_valid", decode_if.valid, 0);
            chk("rst_out_instr", decode_if.instr, NOP);
            chk("rst_out_pc", decode_if.pc, 0);
            chk("rst_opcode", out_opcode, NOP >> (INSTR_W - OPC_W));
            chk("rst_occupancy", occupancy, 0);
            chk("rst_in_ready", fetch_if.ready, 1);
            chk("rst_stall", stall_count, 0);
        end
        exp_q.delete();
        stall_model = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int          stall_exp[6] = '{1, 2, 3, 3, 3, 3};
    logic [31:0] s_ins[3] = '{32'h2001_0005, 32'h2002_0006, 32'h0022_1820};
    logic [5:0]  s_opc[3] = '{6'h08, 6'h08, 6'h00};
    int          d0;
    logic        r0;

    initial begin
        fetch_if.valid  = 1'b0;
        fetch_if.instr  = '0;
        fetch_if.pc     = '0;
        decode_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream with an entry held.
        cyc(1, 32'h8C22_0004, 32'h10, 0, 0);
        mid_reset(1);

        // Stall counter saturation, then flush leaves it untouched.
        cyc(1, 32'hABCD_0001, 32'h100, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            chk("stall_seq", stall_count, stall_exp[k]);
        end
        cyc(0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("stall_after_flush", stall_count, 3);
        chk("occ_after_flush", occupancy, 0);

        // Streaming with out_ready high: one-cycle latency, back-to-back.
        for (int k = 0; k < 3; k++) begin
            cyc(1, s_ins[k], 32'(4 * k), 1, 0);
            @(posedge clk);
            #1;
            chk("stream_valid", decode_if.valid, 1);
            chk("stream_instr", decode_if.instr, s_ins[k]);
            chk("stream_pc", decode_if.pc, 4 * k);
            chk("stream_opcode", out_opcode, s_opc[k]);
            chk("stream_in_ready", fetch_if.ready, 1);
        end
        cyc(0, 0, 0, 1, 0);

        // Back-pressure: fill, hold the third at fetch, then drain in order.
        d0 = delivered;
        cyc(1, 32'hA000_000A, 32'h20, 0, 0);
        @(posedge clk); #1;
        chk("bp_occ1", occupancy, 1);
        chk("bp_rdy1", fetch_if.ready, 1);
        cyc(1, 32'hB000_000B, 32'h24, 0, 0);
        @(posedge clk); #1;
        chk("bp_occ2", occupancy, 2);
        chk("bp_rdy2", fetch_if.ready, 0);
        cyc(1, 32'hC000_000C, 32'h28, 0, 0);
        @(posedge clk); #1;
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_head", decode_if.instr, 32'hA000_000A);
        cyc(1, 32'hC000_000C, 32'h28, 1, 0);
        @(posedge clk); #1;
        chk("bp_drain_b", decode_if.instr, 32'hB000_000B);
        chk("bp_rdy_back", fetch_if.ready, 1);
        cyc(1, 32'hC000_000C, 32'h28, 1, 0);
        @(posedge clk); #1;
        chk("bp_drain_c", decode_if.instr, 32'hC000_000C);
        cyc(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        chk("bp_empty", decode_if.valid, 0);
        chk("bp_count", delivered - d0, 3);

        // Flush while FULL with a new entry offered.
        cyc(1, 32'hD000_0000, 32'h40, 0, 0);
        cyc(1, 32'hD000_0001, 32'h44, 0, 0);
        cyc(1, 32'hD000_0002, 32'h48, 0, 1);
        @(posedge clk); #1;
        chk("fl_valid", decode_if.valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_rdy", fetch_if.ready, 1);
        chk("fl_instr", decode_if.instr, NOP);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Randomized traffic with occasional flushes.
        mid_reset(0);
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom % 10) < 7, $urandom, $urandom & 32'hFFFF_FFFC,
                ($urandom % 10) < 6, ($urandom % 20) == 0);
            r0 = fetch_if.ready;
            #1 decode_if.ready = ~decode_if.ready;
            #1 chk("in_ready_no_comb", fetch_if.ready, r0);
            decode_if.ready = ~decode_if.ready;
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage: carries fetched instruction word and its PC from fetch to decode through a two-entry skid buffer with valid/ready handshake on both sides. Supports synchronous flush (branch/jump redirect), bubble insertion as a configurable NOP word, decoded opcode output and a saturating stall-cycle counter. in_ready is a pure register output, so downstream back-pressure never forms a combinational path into fetch.

## Interface
- INSTR_W, 32, instruction word width
- PC_W, 32, PC width
- OPC_W, 6, opcode field width (taken from instruction MSBs)
- NOP_WORD, 0, instruction value presented when the stage holds no valid entry
- CNT_W, 16, stall counter width

- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode consumes entry this cycle
- out_instr  out  INSTR_W  head instruction, NOP_WORD when !out_valid
- out_pc  out  PC_W  head PC, 0 when !out_valid
- out_opcode  out  OPC_W  out_instr[INSTR_W-1 -: OPC_W]
- occupancy  out  2  entries held: 0, 1 or 2
- stall_count  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Two registers: main (drives outputs) and skid. in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States EMPTY (occ 0), ONE (occ 1), FULL (occ 2); out_valid = (state != EMPTY); in_ready = (state != FULL), registered.
- EMPTY: in_fire -> main <= input, ONE. Else stay.
- ONE: in_fire && out_fire -> main <= input, ONE. in_fire only -> skid <= input, FULL. out_fire only -> EMPTY, main data <= NOP_WORD/0. Neither -> hold.
- FULL: in_fire impossible. out_fire -> main <= skid, skid cleared, ONE. Else hold.
- Order preserved strictly: skid entry always older than any later input, never overtaken.
- flush: highest priority after reset. Next state EMPTY, both data regs <= NOP_WORD / PC 0; any in_fire or out_fire in the flush cycle is treated as completed handshake but the input entry is discarded.
- stall_count: increments by 1 each cycle with out_valid && !out_ready, holds at 2^CNT_W-1; unaffected by flush; cleared only by reset.
- out_opcode is combinational from main register only.

## Timing
- Reset (asserted, async): state EMPTY, out_valid 0, in_ready 1, out_instr NOP_WORD, out_pc 0, out_opcode NOP_WORD MSBs, occupancy 0, stall_count 0. Deassertion takes effect at next edge.
- Latency: in_fire at edge N -> out_valid and data at N+1 (1 cycle). Throughput 1 entry/cycle with out_ready held high.
- in_ready falls one cycle after the stage fills (after an in_fire without out_fire in ONE); it rises the cycle after out_fire in FULL.
- Outputs stable while out_valid && !out_ready (no change until out_fire or flush).
- Simultaneous flush and reset: reset wins. Flush with state FULL: both entries dropped in one cycle, in_ready 1 next cycle.

## Test plan
- Reset mid-stream: load 0x8C220004 @PC 0x10, assert reset between edges -> out_valid 0, out_instr NOP_WORD, occupancy 0 immediately, stall_count 0.
- Streaming: out_ready=1, feed 0x20010005,0x20020006,0x00221820 @PCs 0,4,8 -> each appears 1 cycle later, back-to-back, out_opcode 0x08,0x08,0x00, in_ready stays 1.
- Back-pressure: out_ready=0, feed 3 entries -> occupancy 1 then 2, in_ready 0 after second accepted, third held at fetch; release out_ready -> order A,B,C, no loss/duplication.
- Flush in FULL with in_valid high: next cycle out_valid 0, occupancy 0, in_ready 1, out_instr NOP_WORD; flushed input not seen.
- Stall counter: CNT_W=2, hold out_valid with out_ready=0 for 6 cycles -> stall_count 1,2,3,3,3,3; flush leaves it at 3.
- Random valid/ready with flushes vs scoreboard model: in-order delivery, no combinational dependence of in_ready on out_ready.
